// File: rtl/ip_z80_rom_bridge.sv
// rtl/ip_z80_rom_bridge.sv - Z80 memory-bus to boot-ROM read bridge
// Synchronises the Z80 strobes, decodes the ROM window and stretches the cycle with WAIT until data returns.
module ip_z80_rom_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ROM_BASE    = 16'h0000,
  parameter int          TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_address,
  input  logic        bus_n_mreq,
  input  logic        bus_n_rd,
  input  logic        bus_n_wr,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_oe,
  output logic        bus_n_wait,
  output logic        bus_error,
  output logic        rom_n_cs,
  output logic        rom_n_rd,
  output logic [9:0]  rom_address,
  input  logic [7:0]  rom_rdata,
  input  logic        rom_rdata_en
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_IGNORE = 2'd3;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] mreq_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;

  logic       mreq_s;
  logic       rd_s;
  logic       wr_s;
  logic       req_q;
  logic       hit_q;
  logic       rel_q;
  logic [9:0] addr_q;

  logic [1:0] state;
  logic [7:0] count;
  logic       armed;

  // Synchroniser flops are left unreset so a reset cannot fake a strobe release.
  always_ff @(posedge clk) begin
    mreq_sync <= {mreq_sync[SYNC_STAGES-2:0], bus_n_mreq};
    rd_sync   <= {rd_sync[SYNC_STAGES-2:0], bus_n_rd};
    wr_sync   <= {wr_sync[SYNC_STAGES-2:0], bus_n_wr};
  end

  assign mreq_s = mreq_sync[SYNC_STAGES-1];
  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign wr_s   = wr_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      hit_q  <= 1'b0;
      rel_q  <= 1'b0;
      addr_q <= 10'd0;
    end else begin
      req_q  <= !mreq_s && !rd_s && wr_s;
      hit_q  <= !mreq_s && !rd_s && wr_s && (bus_address[15:10] == ROM_BASE[15:10]);
      rel_q  <= mreq_s || rd_s;
      addr_q <= bus_address[9:0];
    end
  end

  // armed enforces the high-then-low rearm rule, including after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      count        <= 8'd0;
      armed        <= 1'b0;
      bus_rdata    <= 8'h00;
      bus_rdata_oe <= 1'b0;
      bus_n_wait   <= 1'b1;
      bus_error    <= 1'b0;
      rom_n_cs     <= 1'b1;
      rom_n_rd     <= 1'b1;
      rom_address  <= 10'd0;
    end else begin
      bus_error <= 1'b0;
      if (rel_q) begin
        armed <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (armed && hit_q) begin
            state       <= S_ACCESS;
            rom_address <= addr_q;
            rom_n_cs    <= 1'b0;
            rom_n_rd    <= 1'b0;
            bus_n_wait  <= 1'b0;
            count       <= 8'd0;
            armed       <= 1'b0;
          end else if (armed && req_q) begin
            state <= S_IGNORE;
            armed <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (rom_rdata_en) begin
            state        <= S_HOLD;
            bus_rdata    <= rom_rdata;
            bus_rdata_oe <= 1'b1;
            bus_n_wait   <= 1'b1;
            rom_n_cs     <= 1'b1;
            rom_n_rd     <= 1'b1;
          end else if (count == TO_LAST) begin
            state        <= S_HOLD;
            bus_rdata    <= 8'hFF;
            bus_rdata_oe <= 1'b1;
            bus_n_wait   <= 1'b1;
            bus_error    <= 1'b1;
            rom_n_cs     <= 1'b1;
            rom_n_rd     <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        S_HOLD: begin
          if (rel_q) begin
            state        <= S_IDLE;
            bus_rdata_oe <= 1'b0;
          end
        end
        S_IGNORE: begin
          if (rel_q) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_z80_rom_bridge.sv
// tb/tb_ip_z80_rom_bridge.sv - directed bench for ip_z80_rom_bridge
// A transaction-level model predicts every output each cycle; literal checks pin key latencies and bytes.
module tb_ip_z80_rom_bridge;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_address = 16'h0000;
  logic        bus_n_mreq = 1'b1;
  logic        bus_n_rd = 1'b1;
  logic        bus_n_wr = 1'b1;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_oe;
  logic        bus_n_wait;
  logic        bus_error;
  logic        rom_n_cs;
  logic        rom_n_rd;
  logic [9:0]  rom_address;
  logic [7:0]  rom_rdata = 8'h00;
  logic        rom_rdata_en = 1'b0;

  always #5 clk = ~clk;

  ip_z80_rom_bridge #(.SYNC_STAGES(2), .ROM_BASE(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus_address(bus_address),
    .bus_n_mreq(bus_n_mreq), .bus_n_rd(bus_n_rd), .bus_n_wr(bus_n_wr),
    .bus_rdata(bus_rdata), .bus_rdata_oe(bus_rdata_oe), .bus_n_wait(bus_n_wait),
    .bus_error(bus_error), .rom_n_cs(rom_n_cs), .rom_n_rd(rom_n_rd),
    .rom_address(rom_address), .rom_rdata(rom_rdata), .rom_rdata_en(rom_rdata_en)
  );

  logic [7:0] rom [0:1023];
  logic       dead = 1'b0;

  // ROM stub: data-valid one cycle after it samples n_cs=n_rd=0.
  always @(posedge clk) begin
    rom_rdata_en <= !dead && !rom_n_cs && !rom_n_rd;
    rom_rdata    <= rom[rom_address];
  end

  int total = 0;
  int bad = 0;
  int cs_falls = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        mreq;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
  } samp_t;

  typedef enum {M_IDLE, M_WAITDATA, M_DRIVE, M_SKIP} mode_t;

  initial begin
    samp_t  hq[$];
    samp_t  v;
    mode_t  mode = M_IDLE;
    logic   armed = 1'b0;
    logic   rel, req, hit, prev_cs;
    int     n = 0;
    int     t0 = 0;
    logic [7:0] e_rdata = 8'h00;
    logic [9:0] e_addr = 10'd0;
    logic   e_oe = 1'b0, e_wait = 1'b1, e_err = 1'b0, e_cs = 1'b1;
    prev_cs = 1'b1;
    for (int i = 0; i < 3; i++) hq.push_back('{1'b1, 1'b1, 1'b1, 16'h0000});
    forever begin
      @(posedge clk);
      hq.push_back('{bus_n_mreq, bus_n_rd, bus_n_wr, bus_address});
      // The bridge acts on what the bus showed three edges ago.
      v = hq.pop_front();
      n++;
      if (reset) begin
        e_rdata = 8'h00; e_oe = 1'b0; e_wait = 1'b1; e_err = 1'b0; e_cs = 1'b1;
        e_addr = 10'd0; mode = M_IDLE; armed = 1'b0;
      end else begin
        rel = v.mreq || v.rd;
        req = !v.mreq && !v.rd && v.wr;
        hit = req && (v.addr[15:10] == 6'd0);
        e_err = 1'b0;
        case (mode)
          M_IDLE: begin
            if (armed && hit) begin
              mode = M_WAITDATA; t0 = n; e_addr = v.addr[9:0];
              e_cs = 1'b0; e_wait = 1'b0; armed = 1'b0;
            end else if (armed && req) begin
              mode = M_SKIP; armed = 1'b0;
            end
          end
          M_WAITDATA: begin
            if (!dead && n == t0 + 2) begin
              mode = M_DRIVE; e_rdata = rom[e_addr]; e_oe = 1'b1; e_wait = 1'b1; e_cs = 1'b1;
            end else if (n == t0 + TIMEOUT) begin
              mode = M_DRIVE; e_rdata = 8'hFF; e_oe = 1'b1; e_wait = 1'b1; e_cs = 1'b1; e_err = 1'b1;
            end
          end
          M_DRIVE: if (rel) begin mode = M_IDLE; e_oe = 1'b0; end
          M_SKIP:  if (rel) mode = M_IDLE;
          default: mode = M_IDLE;
        endcase
        if (rel) armed = 1'b1;
      end
      #2;
      if (n >= 2) begin
        check("model_rdata", {8'h00, bus_rdata}, {8'h00, e_rdata});
        check("model_oe", {15'd0, bus_rdata_oe}, {15'd0, e_oe});
        check("model_wait", {15'd0, bus_n_wait}, {15'd0, e_wait});
        check("model_error", {15'd0, bus_error}, {15'd0, e_err});
        check("model_cs", {15'd0, rom_n_cs}, {15'd0, e_cs});
        check("model_rd", {15'd0, rom_n_rd}, {15'd0, e_cs});
        check("model_addr", {6'd0, rom_address}, {6'd0, e_addr});
      end
      if (prev_cs && !rom_n_cs) cs_falls++;
      if (bus_error) err_pulses++;
      prev_cs = rom_n_cs;
    end
  end

  task automatic edges(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] exp, input string name);
    bus_address = addr; bus_n_mreq = 1'b0; bus_n_rd = 1'b0;
    edges(10);
    check(name, {7'd0, bus_rdata_oe, bus_rdata}, {8'h01, exp});
    bus_n_mreq = 1'b1; bus_n_rd = 1'b1;
    edges(5);
  endtask

  initial begin
    int base_cs;
    int i;
    for (int a = 0; a < 1024; a++) rom[a] = 8'(a) ^ 8'hA5;
    rom[0] = 8'hF3; rom[1] = 8'h31; rom[3] = 8'h5A; rom[10'h04C] = 8'hC9;

    edges(4);
    reset = 1'b0;
    check("reset_vals", {bus_rdata, bus_rdata_oe, bus_n_wait, bus_error, rom_n_cs, rom_n_rd, 3'd0},
          {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0});
    check("reset_addr", {6'd0, rom_address}, 16'h0000);
    edges(3);

    // Read 0x0000: wait low after edges 3-4, data after edge 5.
    bus_address = 16'h0000; bus_n_mreq = 1'b0; bus_n_rd = 1'b0;
    edges(3);
    check("f3_wait_e2", {15'd0, bus_n_wait}, 16'd1);
    edges(1);
    check("f3_wait_e3", {14'd0, bus_n_wait, rom_n_cs}, 16'd0);
    edges(1);
    check("f3_wait_e4", {15'd0, bus_n_wait}, 16'd0);
    edges(1);
    check("f3_data_e5", {6'd0, bus_n_wait, bus_rdata_oe, bus_rdata}, {8'h03, 8'hF3});
    edges(4);
    check("f3_hold", {8'd0, bus_rdata}, 16'h00F3);
    bus_n_mreq = 1'b1; bus_n_rd = 1'b1;
    edges(3);
    check("f3_oe_rel_e2", {15'd0, bus_rdata_oe}, 16'd1);
    edges(1);
    check("f3_oe_rel_e3", {15'd0, bus_rdata_oe}, 16'd0);
    edges(3);

    base_cs = cs_falls;
    do_read(16'h004C, 8'hC9, "read_004c");
    do_read(16'h0001, 8'h31, "read_0001");
    check("b2b_cs_pulses", 16'(cs_falls - base_cs), 16'd2);

    // Outside the window.
    base_cs = cs_falls;
    bus_address = 16'h8000; bus_n_mreq = 1'b0; bus_n_rd = 1'b0;
    edges(8);
    check("outside", {13'd0, bus_rdata_oe, bus_n_wait, rom_n_cs}, 16'b011);
    bus_n_mreq = 1'b1; bus_n_rd = 1'b1;
    edges(5);
    check("outside_cs", 16'(cs_falls - base_cs), 16'd0);

    // Dead ROM: forced completion after TIMEOUT access cycles.
    dead = 1'b1;
    base_cs = err_pulses;
    bus_address = 16'h0002; bus_n_mreq = 1'b0; bus_n_rd = 1'b0;
    i = 0;
    while (i < 40 && !bus_rdata_oe) begin
      edges(1);
      i++;
    end
    check("timeout_edges", 16'(i), 16'd19);
    check("timeout_data", {6'd0, bus_n_wait, bus_rdata_oe, bus_rdata}, {8'h03, 8'hFF});
    edges(4);
    check("timeout_err_pulses", 16'(err_pulses - base_cs), 16'd1);
    bus_n_mreq = 1'b1; bus_n_rd = 1'b1;
    edges(5);
    dead = 1'b0;

    // Reset mid-access with strobes held low.
    bus_address = 16'h0003; bus_n_mreq = 1'b0; bus_n_rd = 1'b0;
    edges(4);
    check("pre_reset_wait", {15'd0, bus_n_wait}, 16'd0);
    base_cs = cs_falls;
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
    check("midreset_vals", {bus_rdata, bus_rdata_oe, bus_n_wait, bus_error, rom_n_cs, rom_n_rd, 3'd0},
          {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0});
    edges(10);
    check("no_rearm", {13'd0, 16'(cs_falls - base_cs) == 16'd0, bus_n_wait, rom_n_cs}, 16'b111);
    bus_n_mreq = 1'b1; bus_n_rd = 1'b1;
    edges(3);
    do_read(16'h0003, 8'h5A, "read_after_reset");

    // Write cycle never touches the ROM.
    base_cs = cs_falls;
    bus_address = 16'h0005; bus_n_mreq = 1'b0; bus_n_rd = 1'b1; bus_n_wr = 1'b0;
    edges(8);
    check("write", {13'd0, bus_rdata_oe, bus_n_wait, rom_n_cs}, 16'b011);
    bus_n_mreq = 1'b1; bus_n_wr = 1'b1;
    edges(5);
    check("write_cs", 16'(cs_falls - base_cs), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
